// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle between the pipeline, the load/store unit and data memory.
// Latency: none; plain wires grouped so the unit exposes one port.
// Backpressure: req_ready/busy carry the stall; slave = load/store unit, master = pipeline+memory side.
//   req_*  : byte-addressed load/store request (valid/ready accepted in IDLE only)
//   mem_*  : word-addressed data memory access (combinational read, posedge write)
//   resp_* : one-cycle completion pulse with load data, tag and error flag
interface load_store_unit_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;

    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic              resp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  mem_rdata,
        output req_ready, busy,
        output mem_addr, mem_wdata, mem_wr, mem_rd,
        output resp_valid, resp_data, resp_rd, resp_err
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        output mem_rdata,
        input  req_ready, busy,
        input  mem_addr, mem_wdata, mem_wr, mem_rd,
        input  resp_valid, resp_data, resp_rd, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW to 32-bit word memory, sub-word stores via read-modify-write.
// Latency accept->resp_valid: load 2, SW 2, SB/SH 3, error 1 cycle(s).
// Backpressure: req_ready only in IDLE (busy otherwise); req_valid ignored while busy.
//   clk, rst : clock and synchronous active-high reset
//   bus      : load_store_unit_if.slave (request, data memory, response, busy)
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] RMW_READ = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]        state;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;   // only in-range bits survive the error check
    logic [15:0]       wdata_q;  // sub-word store data; SW goes straight to wbuf
    logic [4:0]        rd_q;
    logic [31:0]       wbuf;
    logic [31:0]       resp_data_q;
    logic [4:0]        resp_rd_q;
    logic              resp_err_q;

    logic              req_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;
    logic [31:0]       merged;
    logic              in_mem;

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (|bus.req_addr[31:ADDR_W+2]) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction and extension for loads.
    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_val = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{sgn_q & ld_half[15]}}, ld_half};
            default: ld_val = bus.mem_rdata;
        endcase
    end

    // Old word with the addressed lane replaced by the store data.
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    assign in_mem         = (state == LOAD) || (state == RMW_READ) || (state == WRITE);
    assign bus.mem_addr   = in_mem ? addr_q[ADDR_W+1:2] : '0;
    assign bus.mem_rd     = (state == LOAD) || (state == RMW_READ);
    // A reset landing on the WRITE cycle must not corrupt memory.
    assign bus.mem_wr     = (state == WRITE) && !rst;
    assign bus.mem_wdata  = (state == WRITE) ? wbuf : 32'h0;
    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_err   = resp_err_q;

    // resp_* registers are only written on the edge that enters RESP,
    // so they hold steady from one response to the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sgn_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 16'h0;
            rd_q        <= 5'd0;
            wbuf        <= 32'h0;
            resp_data_q <= 32'h0;
            resp_rd_q   <= 5'd0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        sgn_q   <= bus.req_signed;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr[ADDR_W+1:0];
                        wdata_q <= bus.req_wdata[15:0];
                        rd_q    <= bus.req_rd;
                        if (req_err) begin
                            resp_err_q  <= 1'b1;
                            resp_data_q <= 32'h0;
                            resp_rd_q   <= 5'd0;
                            state       <= RESP;
                        end else if (!bus.req_we) begin
                            state <= LOAD;
                        end else if (bus.req_size == 2'b10) begin
                            wbuf  <= bus.req_wdata;
                            state <= WRITE;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end
                LOAD: begin
                    resp_data_q <= ld_val;
                    resp_rd_q   <= rd_q;
                    resp_err_q  <= 1'b0;
                    state       <= RESP;
                end
                RMW_READ: begin
                    wbuf  <= merged;
                    state <= WRITE;
                end
                WRITE: begin
                    resp_data_q <= 32'h0;
                    resp_rd_q   <= 5'd0;
                    resp_err_q  <= 1'b0;
                    state       <= RESP;
                end
                default: state <= IDLE;  // RESP and any stray encoding
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural 32x32 data memory.
// Inputs driven and outputs sampled just after the falling edge.
// Requests wait for req_ready before being driven.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    load_store_unit_if #(.ADDR_W(5)) bus ();

    load_store_unit #(.ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory model: posedge write, combinational read gated by mem_rd.
    logic [31:0] mem [32];
    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_dat;

    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_we) mem[pl_addr] <= pl_dat;
    end
    assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response cycle.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          output int lat, output int nrd, output int nwr, output logic [4:0] maddr);
        int w = 0;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; maddr = 5'd0;
        while (lat < 10) begin
            if (bus.mem_rd) begin nrd++; maddr = bus.mem_addr; end
            if (bus.mem_wr) begin nwr++; maddr = bus.mem_addr; end
            if (bus.resp_valid) break;
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_err(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] a);
        int lat, nrd, nwr;
        logic [4:0] ma;
        do_req(we, sz, 1'b0, a, 32'h1234_5678, 5'd17, lat, nrd, nwr, ma);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd1);
        chk({tag, "_data"}, bus.resp_data, 32'h0);
        chk({tag, "_rd"}, {27'd0, bus.resp_rd}, 32'd0);
        chk({tag, "_memops"}, nrd + nwr, 32'd0);
    endtask

    task automatic chk_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp);
        int lat, nrd, nwr;
        logic [4:0] ma;
        do_req(1'b0, sz, sg, a, 32'h0, rd, lat, nrd, nwr, ma);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_data"}, bus.resp_data, exp);
        chk({tag, "_rd"}, {27'd0, bus.resp_rd}, {27'd0, rd});
        chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
    endtask

    initial begin
        int lat, nrd, nwr;
        logic [4:0] ma;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
        pl_we = 1'b1; pl_addr = 5'd2; pl_dat = 32'd4;
        @(negedge clk);
        @(negedge clk);
        pl_we = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_mem_ctl", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);

        // LW word 2
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5'd3, lat, nrd, nwr, ma);
        chk("lw8_lat", lat, 32'd2);
        chk("lw8_nrd", nrd, 32'd1);
        chk("lw8_addr", {27'd0, ma}, 32'd2);
        chk("lw8_data", bus.resp_data, 32'd4);
        chk("lw8_rd", {27'd0, bus.resp_rd}, 32'd3);

        // SW then read back
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 5'd7, lat, nrd, nwr, ma);
        chk("sw_lat", lat, 32'd2);
        chk("sw_nwr", nwr, 32'd1);
        chk("sw_nrd", nrd, 32'd0);
        chk("sw_addr", {27'd0, ma}, 32'd5);
        chk("sw_resp_data", bus.resp_data, 32'h0);
        chk("sw_resp_rd", {27'd0, bus.resp_rd}, 32'd0);
        chk("sw_mem", mem[5], 32'hDEADBEEF);
        chk_load("lw14", 2'b10, 1'b0, 32'h14, 5'd4, 32'hDEADBEEF);

        // SB into lane 1
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFF_FFA5, 5'd8, lat, nrd, nwr, ma);
        chk("sb_lat", lat, 32'd3);
        chk("sb_nrd", nrd, 32'd1);
        chk("sb_nwr", nwr, 32'd1);
        chk("sb_mem", mem[5], 32'hDEADA5EF);
        chk_load("lb15", 2'b00, 1'b1, 32'h15, 5'd10, 32'hFFFFFFA5);
        chk_load("lbu15", 2'b00, 1'b0, 32'h15, 5'd11, 32'h000000A5);

        // SH into upper half
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_8001, 5'd9, lat, nrd, nwr, ma);
        chk("sh_lat", lat, 32'd3);
        chk("sh_nwr", nwr, 32'd1);
        chk("sh_mem", mem[5], 32'h8001A5EF);
        chk_load("lh16", 2'b01, 1'b1, 32'h16, 5'd12, 32'hFFFF8001);
        chk_load("lhu16", 2'b01, 1'b0, 32'h16, 5'd13, 32'h00008001);
        chk_load("lbu14", 2'b00, 1'b0, 32'h14, 5'd14, 32'h000000EF);

        // Error cases
        chk_err("lw_mis", 1'b0, 2'b10, 32'h06);
        chk_err("lh_mis", 1'b0, 2'b01, 32'h03);
        chk_err("sw_oor", 1'b1, 2'b10, 32'h80);
        chk_err("sz_ill", 1'b0, 2'b11, 32'h00);
        chk("err_mem_kept", mem[5], 32'h8001A5EF);

        // Reset during the WRITE cycle of an SB
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_addr = 32'h14; bus.req_wdata = 32'h11; bus.req_rd = 5'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstw_rmw_rd", {31'd0, bus.mem_rd}, 32'd1);
        @(negedge clk);
        chk("rstw_write_wr", {31'd0, bus.mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_wr_gated", {31'd0, bus.mem_wr}, 32'd0);
        @(negedge clk);
        chk("rstw_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstw_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rstw_mem", mem[5], 32'h8001A5EF);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_no_resp1", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        chk("rstw_no_resp2", {31'd0, bus.resp_valid}, 32'd0);

        // req_valid held through busy: second accept only once IDLE returns
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h14; bus.req_rd = 5'd9;
        @(negedge clk);
        chk("hold_c1_rd", {30'd0, bus.mem_rd, bus.req_ready}, 32'd2);
        @(negedge clk);
        chk("hold_c2_resp", {30'd0, bus.resp_valid, bus.mem_rd}, 32'd2);
        chk("hold_c2_data", bus.resp_data, 32'h8001A5EF);
        chk("hold_c2_rd", {27'd0, bus.resp_rd}, 32'd9);
        @(negedge clk);
        chk("hold_c3_idle", {29'd0, bus.req_ready, bus.mem_rd, bus.resp_valid}, 32'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("hold_c4_reaccept", {30'd0, bus.mem_rd, bus.req_ready}, 32'd2);
        @(negedge clk);
        chk("hold_c5_resp", {31'd0, bus.resp_valid}, 32'd1);
        @(negedge clk);
        chk("hold_c6_idle", {30'd0, bus.req_ready, bus.mem_rd}, 32'd2);
        @(negedge clk);
        chk("hold_c7_quiet", {30'd0, bus.resp_valid, bus.mem_rd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and the 32x32 word data memory.
- The data memory has 5-bit word addressing, synchronous write on posedge clk when memwr is high, and combinational read when memrd is high; readData is 0 when memrd is low.
- This block turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses. Sub-word stores use a read-modify-write sequence.
- It flags misaligned and out-of-range accesses and returns load data with sign/zero extension.

Parameters:
ADDR_W, 5, word-address width of the data memory (depth 2**ADDR_W words).

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present; accepted only when req_ready=1
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_rd  in  5  destination register tag, echoed on load responses
mem_addr  out  ADDR_W  word address to data memory
mem_wdata  out  32  write data to data memory
mem_wr  out  1  data memory write enable
mem_rd  out  1  data memory read enable
mem_rdata  in  32  data memory read data (combinational)
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result; 0 for stores and errors
resp_rd  out  5  echoed req_rd for loads; 0 for stores and errors
resp_err  out  1  misaligned, illegal size or out-of-range access; valid with resp_valid
busy  out  1  ~req_ready; stall to the pipeline

Behaviour:
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. One-hot or binary encoding is implementation choice.
- Reset:
  - state=IDLE.
  - resp_valid, resp_err, resp_data, resp_rd, and internal latches all 0.
  - mem_rd, mem_wr, mem_addr, mem_wdata are 0 whenever the state is not LOAD/RMW_READ/WRITE.
  - mem_wr is additionally gated by ~rst, so reset asserted in WRITE performs no write at that edge.
- IDLE:
  - On req_valid, latch the request.
  - Error if any of: req_size=11; half with addr[0]≠0; word with addr[1:0]≠0; addr[31:ADDR_W+2]≠0.
  - Error -> RESP with err=1; no memory access.
  - Otherwise: load -> LOAD; word store -> WRITE with wbuf=req_wdata; byte/half store -> RMW_READ.
  - req_valid is ignored in every non-IDLE state.
- Addressing: mem_addr = latched addr[ADDR_W+1:2]. Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
- LOAD:
  - mem_rd=1 for exactly one cycle.
  - At the edge, extract the lane, extend per req_signed, and register into resp_data.
  - resp_rd=tag. Next state RESP.
- RMW_READ:
  - mem_rd=1.
  - At the edge, wbuf = mem_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Next state WRITE.
- WRITE: mem_wr=1, mem_wdata=wbuf for exactly one cycle. Next state RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. The request can be accepted in the same cycle that IDLE is re-entered.
- Latency, counting from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- resp_* hold their values until the next RESP. resp_valid is high only in RESP.
- Reset in any state returns to IDLE at that edge; the in-flight request is dropped with no response.

Test Plan:
- Reset; memory word 2 = 4; LW addr 0x08 -> mem_rd=1 with mem_addr=2 one cycle after accept; resp_valid next cycle with resp_data=4 and resp_rd=tag.
- SW 0xDEADBEEF to addr 0x14 -> one mem_wr pulse, mem_addr=5; LW 0x14 returns 0xDEADBEEF; resp_data=0 on the store response.
- SB 0xA5 to addr 0x15 -> busy for 3 cycles, word 5 becomes 0xDEADA5EF; LB 0x15 returns 0xFFFFFFA5; LBU returns 0x000000A5.
- SH 0x8001 to addr 0x16 -> word 5 becomes 0x8001A5EF; LH 0x16 returns 0xFFFF8001; LHU returns 0x00008001.
- Each of the following gives resp_err=1 after 1 cycle with mem_rd=mem_wr=0 throughout:
  - LW addr 0x06
  - LH addr 0x03
  - SW addr 0x80
  - req_size=11
- Two cases checking reset mid-operation and busy handling:
  - rst asserted during the WRITE of an SB: no mem_wr at that edge, word unchanged, state IDLE, no resp_valid.
  - req_valid held during busy: no second accept until IDLE.
